sram_axi_arbiter: RTL and testbench

Sequences and shares the single AXI slave port of the SRAM wrapper between two masters. M0 is the read-only instruction-fetch port and M1 is the read/write data port. The block sits between the CPU master interfaces and the SRAM wrapper. It grants exactly one burst transaction (read or write) at a time, because the wrapper serializes all traffic through one FSM. Payload is passed through combinationally; grant and state are registered.

---
 rtl/axi_arb_pkg.sv | 27 ++
 rtl/rr_arb3.sv | 32 +++
 rtl/sram_axi_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the SRAM AXI arbiter.
// Slot numbering is also the round-robin search order.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP
  } arb_state_e;

  localparam logic [1:0] SLOT_R0 = 2'd0;
  localparam logic [1:0] SLOT_R1 = 2'd1;
  localparam logic [1:0] SLOT_W1 = 2'd2;

  // Places the master index just above the master's own ID bits.
  function automatic logic [31:0] ext_id(
    input logic [31:0] id,
    input int unsigned id_w,
    input logic        idx
  );
    return id | (32'(idx) << id_w);
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker, purely combinational.
// Search starts at the slot after i_last.
module rr_arb3
  import axi_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    unique case (i_last)
      SLOT_R0: begin
        if (i_req[1])      o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      SLOT_R1: begin
        if (i_req[2])      o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      default: begin
        if (i_req[0])      o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI slave port between an I-fetch reader (M0)
// and a read/write data master (M1), one burst at a time.
module sram_axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     M0_ARID,
  input  logic [ADDR_W-1:0]   M0_ARADDR,
  input  logic [LEN_W-1:0]    M0_ARLEN,
  input  logic [2:0]          M0_ARSIZE,
  input  logic [1:0]          M0_ARBURST,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  output logic [ID_W-1:0]     M0_RID,
  output logic [DATA_W-1:0]   M0_RDATA,
  output logic [1:0]          M0_RRESP,
  output logic                M0_RLAST,
  output logic                M0_RVALID,
  input  logic                M0_RREADY,
  input  logic [ID_W-1:0]     M1_ARID,
  input  logic [ADDR_W-1:0]   M1_ARADDR,
  input  logic [LEN_W-1:0]    M1_ARLEN,
  input  logic [2:0]          M1_ARSIZE,
  input  logic [1:0]          M1_ARBURST,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  output logic [ID_W-1:0]     M1_RID,
  output logic [DATA_W-1:0]   M1_RDATA,
  output logic [1:0]          M1_RRESP,
  output logic                M1_RLAST,
  output logic                M1_RVALID,
  input  logic                M1_RREADY,
  input  logic [ID_W-1:0]     M1_AWID,
  input  logic [ADDR_W-1:0]   M1_AWADDR,
  input  logic [LEN_W-1:0]    M1_AWLEN,
  input  logic [2:0]          M1_AWSIZE,
  input  logic [1:0]          M1_AWBURST,
  input  logic                M1_AWVALID,
  output logic                M1_AWREADY,
  input  logic [DATA_W-1:0]   M1_WDATA,
  input  logic [DATA_W/8-1:0] M1_WSTRB,
  input  logic                M1_WLAST,
  input  logic                M1_WVALID,
  output logic                M1_WREADY,
  output logic [ID_W-1:0]     M1_BID,
  output logic [1:0]          M1_BRESP,
  output logic                M1_BVALID,
  input  logic                M1_BREADY,
  output logic [IDS_W-1:0]    S_ARID,
  output logic [ADDR_W-1:0]   S_ARADDR,
  output logic [LEN_W-1:0]    S_ARLEN,
  output logic [2:0]          S_ARSIZE,
  output logic [1:0]          S_ARBURST,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  input  logic [IDS_W-1:0]    S_RID,
  input  logic [DATA_W-1:0]   S_RDATA,
  input  logic [1:0]          S_RRESP,
  input  logic                S_RLAST,
  input  logic                S_RVALID,
  output logic                S_RREADY,
  output logic [IDS_W-1:0]    S_AWID,
  output logic [ADDR_W-1:0]   S_AWADDR,
  output logic [LEN_W-1:0]    S_AWLEN,
  output logic [2:0]          S_AWSIZE,
  output logic [1:0]          S_AWBURST,
  output logic                S_AWVALID,
  input  logic                S_AWREADY,
  output logic [DATA_W-1:0]   S_WDATA,
  output logic [DATA_W/8-1:0] S_WSTRB,
  output logic                S_WLAST,
  output logic                S_WVALID,
  input  logic                S_WREADY,
  input  logic [IDS_W-1:0]    S_BID,
  input  logic [1:0]          S_BRESP,
  input  logic                S_BVALID,
  output logic                S_BREADY
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic [1:0] r_grant;
  logic [1:0] r_last;
  logic [2:0] w_gnt;
  logic [1:0] w_slot;
  logic       w_sel;

  logic [ID_W-1:0]   w_arid;
  logic [IDS_W-1:0]  w_arid_ext;
  logic [IDS_W-1:0]  w_awid_ext;
  logic [ADDR_W-1:0] w_araddr;
  logic [LEN_W-1:0]  w_arlen;
  logic [2:0]        w_arsize;
  logic [1:0]        w_arburst;
  logic              w_arvalid;
  logic              w_rready;
  logic              w_unused;

  rr_arb3 u_rr (
    .i_req  ({M1_AWVALID, M1_ARVALID, M0_ARVALID}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_slot = w_gnt[2] ? SLOT_W1 :
                  w_gnt[1] ? SLOT_R1 : SLOT_R0;

  // Read grants are only ever R0 or R1, so one bit picks the master.
  assign w_sel     = (r_grant == SLOT_R1);
  assign w_arid    = w_sel ? M1_ARID    : M0_ARID;
  assign w_araddr  = w_sel ? M1_ARADDR  : M0_ARADDR;
  assign w_arlen   = w_sel ? M1_ARLEN   : M0_ARLEN;
  assign w_arsize  = w_sel ? M1_ARSIZE  : M0_ARSIZE;
  assign w_arburst = w_sel ? M1_ARBURST : M0_ARBURST;
  assign w_arvalid = w_sel ? M1_ARVALID : M0_ARVALID;
  assign w_rready  = w_sel ? M1_RREADY  : M0_RREADY;

  assign w_arid_ext = IDS_W'(ext_id(32'(w_arid), ID_W, w_sel));
  assign w_awid_ext = IDS_W'(ext_id(32'(M1_AWID), ID_W, 1'b1));

  assign w_unused = ^{S_RID[IDS_W-1:ID_W], S_BID[IDS_W-1:ID_W]};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_grant <= SLOT_R0;
      r_last  <= SLOT_W1;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && |w_gnt) begin
        r_grant <= w_slot;
        r_last  <= w_slot;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    M0_ARREADY = 1'b0;
    M0_RID     = '0;
    M0_RDATA   = '0;
    M0_RRESP   = '0;
    M0_RLAST   = 1'b0;
    M0_RVALID  = 1'b0;
    M1_ARREADY = 1'b0;
    M1_RID     = '0;
    M1_RDATA   = '0;
    M1_RRESP   = '0;
    M1_RLAST   = 1'b0;
    M1_RVALID  = 1'b0;
    M1_AWREADY = 1'b0;
    M1_WREADY  = 1'b0;
    M1_BID     = '0;
    M1_BRESP   = '0;
    M1_BVALID  = 1'b0;
    S_ARID     = '0;
    S_ARADDR   = '0;
    S_ARLEN    = '0;
    S_ARSIZE   = '0;
    S_ARBURST  = '0;
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    S_AWID     = '0;
    S_AWADDR   = '0;
    S_AWLEN    = '0;
    S_AWSIZE   = '0;
    S_AWBURST  = '0;
    S_AWVALID  = 1'b0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WLAST    = 1'b0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_gnt)
          w_next = w_gnt[2] ? ST_WR_ADDR : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        S_ARID    = w_arid_ext;
        S_ARADDR  = w_araddr;
        S_ARLEN   = w_arlen;
        S_ARSIZE  = w_arsize;
        S_ARBURST = w_arburst;
        S_ARVALID = w_arvalid;
        if (w_sel) M1_ARREADY = S_ARREADY;
        else       M0_ARREADY = S_ARREADY;
        if (w_arvalid && S_ARREADY)
          w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        S_RREADY = w_rready;
        if (w_sel) begin
          M1_RID    = S_RID[ID_W-1:0];
          M1_RDATA  = S_RDATA;
          M1_RRESP  = S_RRESP;
          M1_RLAST  = S_RLAST;
          M1_RVALID = S_RVALID;
        end else begin
          M0_RID    = S_RID[ID_W-1:0];
          M0_RDATA  = S_RDATA;
          M0_RRESP  = S_RRESP;
          M0_RLAST  = S_RLAST;
          M0_RVALID = S_RVALID;
        end
        if (S_RVALID && w_rready && S_RLAST)
          w_next = ST_IDLE;
      end
      ST_WR_ADDR: begin
        S_AWID     = w_awid_ext;
        S_AWADDR   = M1_AWADDR;
        S_AWLEN    = M1_AWLEN;
        S_AWSIZE   = M1_AWSIZE;
        S_AWBURST  = M1_AWBURST;
        S_AWVALID  = M1_AWVALID;
        M1_AWREADY = S_AWREADY;
        if (M1_AWVALID && S_AWREADY)
          w_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        S_WDATA   = M1_WDATA;
        S_WSTRB   = M1_WSTRB;
        S_WLAST   = M1_WLAST;
        S_WVALID  = M1_WVALID;
        M1_WREADY = S_WREADY;
        if (M1_WVALID && S_WREADY && M1_WLAST)
          w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        M1_BID    = S_BID[ID_W-1:0];
        M1_BRESP  = S_BRESP;
        M1_BVALID = S_BVALID;
        S_BREADY  = M1_BREADY;
        if (S_BVALID && M1_BREADY)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter with a small SRAM slave model.
// Read data is a fixed function of the beat address.
module tb_sram_axi_arbiter;
  import axi_arb_pkg::*;

  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic ACLK, ARESET;
  logic [ID_W-1:0] M0_ARID, M1_ARID, M1_AWID;
  logic [ADDR_W-1:0] M0_ARADDR, M1_ARADDR, M1_AWADDR;
  logic [LEN_W-1:0] M0_ARLEN, M1_ARLEN, M1_AWLEN;
  logic [2:0] M0_ARSIZE, M1_ARSIZE, M1_AWSIZE;
  logic [1:0] M0_ARBURST, M1_ARBURST, M1_AWBURST;
  logic M0_ARVALID, M0_ARREADY, M1_ARVALID, M1_ARREADY;
  logic [ID_W-1:0] M0_RID, M1_RID, M1_BID;
  logic [DATA_W-1:0] M0_RDATA, M1_RDATA, M1_WDATA;
  logic [1:0] M0_RRESP, M1_RRESP, M1_BRESP;
  logic M0_RLAST, M0_RVALID, M0_RREADY;
  logic M1_RLAST, M1_RVALID, M1_RREADY;
  logic M1_AWVALID, M1_AWREADY;
  logic [DATA_W/8-1:0] M1_WSTRB;
  logic M1_WLAST, M1_WVALID, M1_WREADY;
  logic M1_BVALID, M1_BREADY;
  logic [IDS_W-1:0] S_ARID, S_RID, S_AWID, S_BID;
  logic [ADDR_W-1:0] S_ARADDR, S_AWADDR;
  logic [LEN_W-1:0] S_ARLEN, S_AWLEN;
  logic [2:0] S_ARSIZE, S_AWSIZE;
  logic [1:0] S_ARBURST, S_AWBURST, S_RRESP, S_BRESP;
  logic S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
  logic S_AWVALID, S_AWREADY;
  logic [DATA_W-1:0] S_WDATA, S_RDATA;
  logic [DATA_W/8-1:0] S_WSTRB;
  logic S_WLAST, S_WVALID, S_WREADY;
  logic S_BVALID, S_BREADY;

  sram_axi_arbiter #(
    .ID_W(ID_W), .IDS_W(IDS_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN),
    .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST),
    .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
    .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN),
    .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST),
    .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
    .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .M1_AWID(M1_AWID), .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN),
    .M1_AWSIZE(M1_AWSIZE), .M1_AWBURST(M1_AWBURST),
    .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST),
    .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BID(M1_BID), .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID),
    .M1_BREADY(M1_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
    .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
    .S_BREADY(S_BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Slave model: always ready on AR/AW/W, one read burst at a time.
  logic              s_rbusy, s_bvalid;
  logic [ADDR_W-1:0] s_raddr;
  logic [LEN_W-1:0]  s_rlen, s_rcnt;
  logic [IDS_W-1:0]  s_rid, s_bid;
  logic [DATA_W-1:0]   wq_d[$];
  logic [DATA_W/8-1:0] wq_s[$];

  assign S_ARREADY = 1'b1;
  assign S_AWREADY = 1'b1;
  assign S_WREADY  = 1'b1;
  assign S_RVALID  = s_rbusy;
  assign S_RDATA   = memf(s_raddr + ADDR_W'({s_rcnt, 2'b00}));
  assign S_RLAST   = s_rbusy && (s_rcnt == s_rlen);
  assign S_RID     = s_rid;
  assign S_RRESP   = 2'b00;
  assign S_BVALID  = s_bvalid;
  assign S_BID     = s_bid;
  assign S_BRESP   = 2'b00;

  always @(posedge ACLK) begin
    if (ARESET) begin
      s_rbusy  <= 1'b0;
      s_bvalid <= 1'b0;
      s_raddr  <= '0;
      s_rlen   <= '0;
      s_rcnt   <= '0;
      s_rid    <= '0;
      s_bid    <= '0;
    end else begin
      if (S_ARVALID && S_ARREADY) begin
        s_rbusy <= 1'b1;
        s_raddr <= S_ARADDR;
        s_rlen  <= S_ARLEN;
        s_rid   <= S_ARID;
        s_rcnt  <= '0;
      end else if (S_RVALID && S_RREADY) begin
        if (S_RLAST) s_rbusy <= 1'b0;
        else         s_rcnt  <= s_rcnt + 1'b1;
      end
      if (S_AWVALID && S_AWREADY) s_bid <= S_AWID;
      if (S_WVALID && S_WREADY) begin
        wq_d.push_back(S_WDATA);
        wq_s.push_back(S_WSTRB);
        if (S_WLAST) s_bvalid <= 1'b1;
      end
      if (S_BVALID && S_BREADY) s_bvalid <= 1'b0;
    end
  end

  // Transaction order log: 0 = M0 read, 1 = M1 read, 2 = M1 write.
  int cyc = 0;
  int ev_k[$];
  int ev_c[$];
  int dn_c[$];

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (!ARESET) begin
      if (S_ARVALID && S_ARREADY) begin
        ev_k.push_back(int'(S_ARID[ID_W]));
        ev_c.push_back(cyc);
      end
      if (S_AWVALID && S_AWREADY) begin
        ev_k.push_back(2);
        ev_c.push_back(cyc);
      end
      if ((S_RVALID && S_RREADY && S_RLAST) || (S_BVALID && S_BREADY))
        dn_c.push_back(cyc);
    end
  end

  logic [DATA_W-1:0] q0_d[$], q1_d[$];
  logic              q0_l[$];
  logic [ID_W-1:0]   q0_id[$];
  arb_state_e        st_q[$];
  int                other_rv;
  bit                wr_done;

  function automatic logic [11:0] vr_outs();
    return {S_ARVALID, S_AWVALID, S_WVALID, S_RREADY, S_BREADY,
            M0_ARREADY, M0_RVALID, M1_ARREADY, M1_RVALID,
            M1_AWREADY, M1_WREADY, M1_BVALID};
  endfunction

  task automatic rd(input int m, input logic [ID_W-1:0] id,
                    input logic [ADDR_W-1:0] addr,
                    input logic [LEN_W-1:0] len, input logic [7:0] rpat,
                    input int stop, output logic [IDS_W-1:0] sid);
    int n, k, c, lim;
    bit ok;
    lim = int'(len) + 1;
    if (stop < lim) lim = stop;
    @(posedge ACLK); #1;
    if (m == 0) begin
      M0_ARID = id; M0_ARADDR = addr; M0_ARLEN = len;
      M0_ARSIZE = 3'd2; M0_ARBURST = 2'b01; M0_ARVALID = 1'b1;
    end else begin
      M1_ARID = id; M1_ARADDR = addr; M1_ARLEN = len;
      M1_ARSIZE = 3'd2; M1_ARBURST = 2'b01; M1_ARVALID = 1'b1;
    end
    ok = 0;
    sid = '0;
    for (c = 0; c < 200 && !ok; c++) begin
      @(negedge ACLK);
      if ((m == 0 && M0_ARREADY) || (m == 1 && M1_ARREADY)) begin
        ok = 1;
        sid = S_ARID;
      end
    end
    chk("ar_grant", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    if (m == 0) M0_ARVALID = 1'b0;
    else        M1_ARVALID = 1'b0;
    n = 0; k = 0; c = 0;
    while (n < lim && c < 200) begin
      if (m == 0) M0_RREADY = rpat[k % 8];
      else        M1_RREADY = rpat[k % 8];
      k++; c++;
      @(negedge ACLK);
      if (m == 0 && M0_RVALID && M0_RREADY) begin
        q0_d.push_back(M0_RDATA);
        q0_l.push_back(M0_RLAST);
        q0_id.push_back(M0_RID);
        st_q.push_back(dut.r_state);
        if (M1_RVALID) other_rv++;
        n++;
      end else if (m == 1 && M1_RVALID && M1_RREADY) begin
        q1_d.push_back(M1_RDATA);
        n++;
      end
      @(posedge ACLK); #1;
    end
    chk("rd_beats", 64'(n), 64'(lim));
    if (m == 0) M0_RREADY = 1'b0;
    else        M1_RREADY = 1'b0;
  endtask

  task automatic wr(input logic [ID_W-1:0] id,
                    input logic [ADDR_W-1:0] addr,
                    input logic [LEN_W-1:0] len,
                    input logic [DATA_W-1:0] dbase,
                    input logic [DATA_W/8-1:0] strb,
                    output logic [ID_W-1:0] bid, output logic [1:0] bresp);
    int c;
    bit ok;
    @(posedge ACLK); #1;
    M1_AWID = id; M1_AWADDR = addr; M1_AWLEN = len;
    M1_AWSIZE = 3'd2; M1_AWBURST = 2'b01;
    M1_AWVALID = 1'b1; M1_BREADY = 1'b1;
    ok = 0;
    for (c = 0; c < 200 && !ok; c++) begin
      @(negedge ACLK);
      ok = M1_AWREADY;
    end
    chk("aw_grant", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    M1_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      M1_WDATA  = dbase + DATA_W'(b);
      M1_WSTRB  = strb;
      M1_WLAST  = (b == int'(len));
      M1_WVALID = 1'b1;
      ok = 0;
      for (c = 0; c < 50 && !ok; c++) begin
        @(negedge ACLK);
        ok = M1_WREADY;
      end
      if (!ok) chk("w_ready", 64'(ok), 64'd1);
      @(posedge ACLK); #1;
    end
    M1_WVALID = 1'b0;
    M1_WLAST  = 1'b0;
    ok = 0; bid = '0; bresp = 2'b11;
    for (c = 0; c < 50 && !ok; c++) begin
      @(negedge ACLK);
      if (M1_BVALID) begin
        ok = 1; bid = M1_BID; bresp = M1_BRESP;
      end
    end
    chk("b_seen", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    M1_BREADY = 1'b0;
    wr_done = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [IDS_W-1:0] sa, sb, sc;
    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    int               bad, saw;

    ARESET = 1'b1;
    {M0_ARID, M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST} = '0;
    {M1_ARID, M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST} = '0;
    {M1_AWID, M1_AWADDR, M1_AWLEN, M1_AWSIZE, M1_AWBURST} = '0;
    {M1_WDATA, M1_WSTRB, M1_WLAST} = '0;
    M0_ARVALID = 0; M0_RREADY = 0; M1_ARVALID = 0; M1_RREADY = 0;
    M1_AWVALID = 0; M1_WVALID = 0; M1_BREADY = 0;
    other_rv = 0; wr_done = 0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_outs", 64'(vr_outs()), 64'd0);
    chk("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    chk("rst_last", 64'(dut.r_last), 64'(SLOT_W1));
    ARESET = 1'b0;

    // Single M0 read.
    rd(0, 4'd3, 32'h0000_0010, 4'd0, 8'hFF, 99, sa);
    chk("t1_arid", 64'(sa), 64'h03);
    chk("t1_nbeat", 64'(q0_d.size()), 64'd1);
    chk("t1_data", 64'(q0_d[0]), 64'(memf(32'h10)));
    chk("t1_last", 64'(q0_l[0]), 64'd1);
    chk("t1_rid", 64'(q0_id[0]), 64'd3);
    chk("t1_m1_rvalid", 64'(other_rv), 64'd0);

    // Three simultaneous requests straight after reset.
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    ev_k.delete(); ev_c.delete(); dn_c.delete(); q1_d.delete();
    fork
      rd(0, 4'd1, 32'h20, 4'd0, 8'hFF, 99, sa);
      rd(1, 4'd2, 32'h30, 4'd0, 8'hFF, 99, sb);
      wr(4'd5, 32'h40, 4'd0, 32'hAAAA_0000, 4'hF, bid, bresp);
    join
    chk("t2_first", 64'(ev_k[0]), 64'd0);
    chk("t2_second", 64'(ev_k[1]), 64'd1);
    chk("t2_third", 64'(ev_k[2]), 64'd2);
    chk("t2_gap1", 64'(ev_c[1] - dn_c[0]), 64'd2);
    chk("t2_gap2", 64'(ev_c[2] - dn_c[1]), 64'd2);
    chk("t2_m1_arid", 64'(sb), 64'h12);
    chk("t2_m1_data", 64'(q1_d[0]), 64'(memf(32'h30)));

    // M1 write burst while M0 waits on AR.
    wq_d.delete(); wq_s.delete(); q0_d.delete(); q0_l.delete();
    wr_done = 0; bad = 0; saw = 0;
    fork
      wr(4'd7, 32'h80, 4'd3, 32'h1111_0000, 4'b0011, bid, bresp);
      begin
        repeat (2) @(posedge ACLK);
        rd(0, 4'd4, 32'h60, 4'd0, 8'hFF, 99, sc);
      end
      begin
        while (!wr_done) begin
          @(negedge ACLK);
          if (M0_ARREADY) bad++;
          if (M0_ARVALID) saw++;
        end
      end
    join
    chk("t3_nbeat", 64'(wq_d.size()), 64'd4);
    for (int b = 0; b < 4; b++) begin
      chk("t3_wdata", 64'(wq_d[b]), 64'(32'h1111_0000 + b));
      chk("t3_wstrb", 64'(wq_s[b]), 64'h3);
    end
    chk("t3_bid", 64'(bid), 64'd7);
    chk("t3_bresp", 64'(bresp), 64'd0);
    chk("t3_m0_waited", 64'(saw > 0), 64'd1);
    chk("t3_m0_arready", 64'(bad), 64'd0);
    chk("t3_m0_data", 64'(q0_d[0]), 64'(memf(32'h60)));

    // M0 burst with RREADY toggling.
    q0_d.delete(); q0_l.delete(); st_q.delete();
    rd(0, 4'd6, 32'h100, 4'd3, 8'b0101_0101, 99, sa);
    chk("t4_idle_after", 64'(dut.r_state), 64'(ST_IDLE));
    chk("t4_nbeat", 64'(q0_d.size()), 64'd4);
    for (int b = 0; b < 4; b++) begin
      chk("t4_data", 64'(q0_d[b]), 64'(memf(32'h100 + 32'(4 * b))));
      chk("t4_last", 64'(q0_l[b]), 64'(b == 3));
      chk("t4_state", 64'(st_q[b]), 64'(ST_RD_DATA));
    end

    // Reset in the middle of a 4-beat read.
    q0_d.delete();
    rd(0, 4'd8, 32'h200, 4'd3, 8'hFF, 1, sa);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("t5_outs", 64'(vr_outs()), 64'd0);
    chk("t5_state", 64'(dut.r_state), 64'(ST_IDLE));
    ARESET = 1'b0;
    ev_k.delete(); ev_c.delete(); dn_c.delete();
    q0_d.delete(); q1_d.delete();
    fork
      rd(1, 4'd9, 32'h300, 4'd0, 8'hFF, 99, sb);
      rd(0, 4'd10, 32'h400, 4'd0, 8'hFF, 99, sa);
    join
    chk("t5_first", 64'(ev_k[0]), 64'd0);
    chk("t5_second", 64'(ev_k[1]), 64'd1);
    chk("t5_m0_data", 64'(q0_d[0]), 64'(memf(32'h400)));
    chk("t5_m1_data", 64'(q1_d[0]), 64'(memf(32'h300)));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
